// File: rtl/mem_arbiter.sv
// Two-master round-robin memory arbiter.
// Each accepted request is latched, checked against the address map, and
// either issued as a one-cycle write, waited on as a read, or rejected.
module mem_arbiter #(
    parameter int N      = 32,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         m0_req,
    input  logic         m1_req,
    input  logic         m0_we,
    input  logic         m1_we,
    input  logic [N-1:0] m0_addr,
    input  logic [N-1:0] m1_addr,
    input  logic [N-1:0] m0_wdata,
    input  logic [N-1:0] m1_wdata,
    output logic         m0_gnt,
    output logic         m1_gnt,
    output logic         m0_rvalid,
    output logic         m1_rvalid,
    output logic         m0_err,
    output logic         m1_err,
    output logic [N-1:0] rdata,
    output logic         bus_we,
    output logic [N-1:0] bus_addr,
    output logic [N-1:0] bus_wdata,
    input  logic [N-1:0] bus_rdata,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    // Address map boundaries (inclusive).
    localparam logic [N-1:0] RW_ID_HI = N'(32'h0000_0403); // regs + read-only id word
    localparam logic [N-1:0] RW_HI    = N'(32'h0000_03FF);
    localparam logic [N-1:0] WO_LO    = N'(32'h0000_0404);
    localparam logic [N-1:0] WO_HI    = N'(32'h0002_5C03);
    localparam logic [N-1:0] RO_LO    = N'(32'h0003_0000);
    localparam logic [N-1:0] RO_HI    = N'(32'h0007_AFFF);

    state_t         state, state_nxt;
    logic [1:0]     req;
    logic           sel_nxt;
    logic           sel;       // master currently being served
    logic           last;      // master granted most recently
    logic           lat_we;
    logic [N-1:0]   lat_addr;
    logic [N-1:0]   lat_wdata;
    logic [2:0]     cnt;
    logic [1:0]     rvalid_q;
    logic [N-1:0]   rdata_q;
    logic [1:0]     gnt_v;
    logic [1:0]     err_v;
    logic           bus_we_c;
    logic           rd_legal, wr_legal, legal;

    assign req = {m1_req, m0_req};

    // Round-robin pick: on a tie the master not granted last wins.
    assign sel_nxt = (req == 2'b11) ? ~last : req[1];

    // Legality of the latched access.
    assign rd_legal = (lat_addr <= RW_ID_HI) || ((lat_addr >= RO_LO) && (lat_addr <= RO_HI));
    assign wr_legal = (lat_addr <= RW_HI) || ((lat_addr >= WO_LO) && (lat_addr <= WO_HI));
    assign legal    = lat_we ? wr_legal : rd_legal;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and per-cycle strobes.
    always_comb begin
        state_nxt = state;
        gnt_v     = '0;
        err_v     = '0;
        bus_we_c  = 1'b0;
        case (state)
            IDLE:  if (|req) state_nxt = ISSUE;
            ISSUE: begin
                gnt_v[sel] = 1'b1;
                err_v[sel] = ~legal;
                bus_we_c   = lat_we & legal;
                state_nxt  = (legal && !lat_we) ? WAIT : IDLE;
            end
            WAIT:  if (cnt <= 3'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, read-latency counter and read-return registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel       <= 1'b0;
            last      <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
        end else begin
            rvalid_q <= '0;
            case (state)
                IDLE: if (|req) begin
                    sel       <= sel_nxt;
                    last      <= sel_nxt;
                    lat_we    <= sel_nxt ? m1_we    : m0_we;
                    lat_addr  <= sel_nxt ? m1_addr  : m0_addr;
                    lat_wdata <= sel_nxt ? m1_wdata : m0_wdata;
                end
                ISSUE: if (legal && !lat_we) cnt <= 3'(RD_LAT);
                WAIT: begin
                    cnt <= (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
                    // Counter hits zero this cycle: capture data, rvalid next cycle.
                    if (cnt <= 3'd1) begin
                        rdata_q       <= bus_rdata;
                        rvalid_q[sel] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m0_gnt    = gnt_v[0];
    assign m1_gnt    = gnt_v[1];
    assign m0_err    = err_v[0];
    assign m1_err    = err_v[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign rdata     = rdata_q;
    assign bus_we    = bus_we_c;
    assign bus_addr  = lat_addr;
    assign bus_wdata = lat_wdata;
    assign busy      = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N, default 32, data and address width in bits.
REQ-002 Parameter RD_LAT, default 1, cycles from bus read issue to bus_rdata valid (legal range 1..4).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 m0_req, m1_req  input  1 each  access request; held high with stable attributes until the matching gnt.
REQ-006 m0_we, m1_we  input  1 each  1 = write, 0 = read.
REQ-007 m0_addr, m1_addr  input  N each  byte address.
REQ-008 m0_wdata, m1_wdata  input  N each  write data.
REQ-009 m0_gnt, m1_gnt  output  1 each  one-cycle pulse: request accepted and issued.
REQ-010 m0_rvalid, m1_rvalid  output  1 each  one-cycle pulse: rdata valid for that master.
REQ-011 m0_err, m1_err  output  1 each  one-cycle pulse, coincident with gnt: access illegal, not issued.
REQ-012 rdata  output  N  read data shared by both masters, qualified by mX_rvalid.
REQ-013 bus_we  output  1  write enable toward the address decoder.
REQ-014 bus_addr  output  N  address toward the address decoder.
REQ-015 bus_wdata  output  N  write data toward the address decoder.
REQ-016 bus_rdata  input  N  read data returned by the address decoder.
REQ-017 busy  output  1  high in every state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-019 IDLE: if any req is high, select one master, latch its we/addr/wdata and its index into internal registers, and go to ISSUE; otherwise stay in IDLE.
REQ-020 Selection SHALL be round-robin: when both masters request, grant the master not granted last; when one requests, grant it.
REQ-021 last-granted SHALL update on every entry to ISSUE.
REQ-022 Legality SHALL be decided from the latched attributes: read legal for addr < 0x400, 0x400..0x403, or 0x30000..0x7AFFF.
REQ-023 Write legal for addr < 0x400 or 0x404..0x25C03; every other address/direction combination is illegal.
REQ-024 ISSUE lasts exactly one cycle and pulses the selected master's gnt.
REQ-025 In ISSUE, bus_addr and bus_wdata SHALL present the latched values.
REQ-026 In ISSUE, bus_we SHALL equal latched we AND legal.
REQ-027 Illegal access in ISSUE: bus_we=0, selected err pulses with gnt, then go to IDLE.
REQ-028 Legal write in ISSUE: go to IDLE; total cost 2 cycles per write.
REQ-029 Legal read in ISSUE: go to WAIT with a down-counter loaded with RD_LAT.
REQ-030 WAIT: bus_addr holds the latched address, bus_we=0, counter decrements each cycle.
REQ-031 When the WAIT counter reaches 0, register bus_rdata into rdata, pulse the selected rvalid in the following cycle, and go to IDLE.
REQ-032 rdata SHALL hold its value until the next read completes.
REQ-033 Requests arriving while busy are not lost: they are arbitrated on return to IDLE.
REQ-034 A master deasserting req before gnt is a protocol violation; behaviour is unspecified.
REQ-035 At most one gnt, one rvalid and one err SHALL be high in any cycle.
REQ-036 The IDLE-to-ISSUE transition SHALL NOT depend on rvalid timing; rvalid of an old read may coincide with IDLE evaluation of a new request.

Reset
REQ-037 While reset is high: state=IDLE, all gnt/rvalid/err=0, busy=0, bus_we=0, bus_addr=0, bus_wdata=0, rdata=0, counter=0.
REQ-038 While reset is high, last-granted SHALL be master 1, so master 0 wins the first tie.
REQ-039 Reset asserted mid-ISSUE or mid-WAIT SHALL abort the access with no gnt, rvalid or err pulse afterwards and no bus_we glitch after reset assertion.

Verification
REQ-040 Reset then m0 write addr 0x10 data 0xDEADBEEF -> m0_gnt in cycle 2, bus_we=1 with bus_addr=0x10, bus_wdata=0xDEADBEEF in that cycle.
REQ-041 m1 read 0x400 with RD_LAT=1, bus_rdata=0x5 -> m1_gnt, then m1_rvalid with rdata=0x5 exactly RD_LAT+1 cycles after gnt.
REQ-042 m0 and m1 request continuously from reset -> grants alternate m0, m1, m0, m1.
REQ-043 m0 write to 0x30000 (read-only region) -> m0_gnt and m0_err same cycle, bus_we=0, no rvalid.
REQ-044 m1 read 0x404 (write-only region) -> m1_err, bus_we=0, no rvalid; m0 write 0x25C04 -> m0_err.
REQ-045 Reset asserted during WAIT of m0 read 0x7AFFC -> all outputs 0 immediately, no m0_rvalid after reset release.
